// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the memory-access stage.
package mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef enum logic {IDLE, WAIT} mem_state_e;

    // Size 2'b11 falls into the word rule.
    function automatic logic mem_is_aligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            MEM_BYTE: return 1'b1;
            MEM_HALF: return ~offset[0];
            default:  return offset == 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] mem_store_be(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            MEM_BYTE: return 4'b0001 << offset;
            MEM_HALF: return offset[1] ? 4'b1100 : 4'b0011;
            default:  return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] mem_store_data(input logic [1:0] size,
                                                   input logic [31:0] data);
        case (size)
            MEM_BYTE: return {4{data[7:0]}};
            MEM_HALF: return {2{data[15:0]}};
            default:  return data;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half lane of a read word and sign/zero extends it.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = 8'h00;
        unique case (offset)
            2'b00: byte_lane = rdata[7:0];
            2'b01: byte_lane = rdata[15:8];
            2'b10: byte_lane = rdata[23:16];
            2'b11: byte_lane = rdata[31:24];
        endcase

        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            MEM_BYTE: data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
            MEM_HALF: data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
            default:  data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data-memory req/ack port, stalls upstream while
// an access is outstanding and presents the MEM/WB register inputs.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] In_Address,
    input  logic [31:0] In_Store_Data,
    input  logic        In_MemRead,
    input  logic        In_MemWrite,
    input  logic [1:0]  In_MemSize,
    input  logic        In_MemUnsigned,
    input  logic [4:0]  In_Rd,
    input  logic        In_RegWrite,
    input  logic [1:0]  In_MemtoReg,
    input  logic [31:0] In_PC,
    input  logic        In_halt,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] Out_RAM_Data,
    output logic [31:0] Out_Immediate_Data,
    output logic [4:0]  Out_Rd,
    output logic        Out_RegWrite,
    output logic [1:0]  Out_MemtoReg,
    output logic [31:0] Out_PC,
    output logic        Out_halt,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

    mem_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [1:0]  offset;
    logic        mem_op;
    logic        aligned;
    logic        access;
    logic        timeout;
    logic        complete;
    logic        is_load;
    logic        bubble;
    logic [31:0] load_data;

    assign offset   = In_Address[1:0];
    assign mem_op   = (In_MemRead | In_MemWrite) & ~In_halt;
    assign aligned  = mem_is_aligned(In_MemSize, offset);
    assign access   = mem_op & aligned;
    assign timeout  = (state_q == WAIT) & ~mem_ack & (cnt_q == CntMax);
    assign complete = ~rst & access & mem_ack;
    assign is_load  = In_MemRead & ~In_MemWrite;

    mem_load_align u_load_align (
        .rdata       (mem_rdata),
        .offset      (offset),
        .size        (In_MemSize),
        .is_unsigned (In_MemUnsigned),
        .data        (load_data)
    );

    // Memory port: the address/data/enables track the EX/MEM inputs, which stay
    // frozen by stall for the whole access.
    always_comb begin
        mem_req   = ~rst & access & ~timeout;
        mem_we    = access & In_MemWrite;
        mem_addr  = {In_Address[31:2], 2'b00};
        mem_be    = In_MemWrite ? mem_store_be(In_MemSize, offset) : 4'b1111;
        mem_wdata = mem_store_data(In_MemSize, In_Store_Data);
    end

    // Anything that is not a completed access or a plain passthrough is a bubble.
    always_comb begin
        stall    = ~rst & access & ~mem_ack & ~timeout;
        misalign = ~rst & mem_op & ~aligned;
        bus_err  = ~rst & access & timeout;
        bubble   = rst | (mem_op & ~aligned) | (access & ~mem_ack);

        Out_RAM_Data       = (complete & is_load) ? load_data : 32'h0;
        Out_Immediate_Data = In_Address;
        Out_Rd             = bubble ? 5'd0 : In_Rd;
        Out_RegWrite       = In_RegWrite & ~bubble;
        Out_MemtoReg       = In_MemtoReg;
        Out_PC             = In_PC;
        Out_halt           = In_halt & ~bubble;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (access && !mem_ack) begin
                    state_d = WAIT;
                    cnt_d   = CntW'(1);
                end
            end
            WAIT: begin
                if (!access || mem_ack || cnt_q == CntMax) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed plus randomized bench for mem_access_stage against a per-instruction model.
module tb_mem_access_stage;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] In_Address, In_Store_Data, In_PC;
    logic        In_MemRead, In_MemWrite, In_MemUnsigned, In_RegWrite, In_halt;
    logic [1:0]  In_MemSize, In_MemtoReg;
    logic [4:0]  In_Rd;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic [31:0] Out_RAM_Data, Out_Immediate_Data, Out_PC;
    logic [4:0]  Out_Rd;
    logic        Out_RegWrite, Out_halt, stall, misalign, bus_err;
    logic [1:0]  Out_MemtoReg;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .In_Address(In_Address), .In_Store_Data(In_Store_Data),
        .In_MemRead(In_MemRead), .In_MemWrite(In_MemWrite), .In_MemSize(In_MemSize),
        .In_MemUnsigned(In_MemUnsigned), .In_Rd(In_Rd), .In_RegWrite(In_RegWrite),
        .In_MemtoReg(In_MemtoReg), .In_PC(In_PC), .In_halt(In_halt),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .Out_RAM_Data(Out_RAM_Data), .Out_Immediate_Data(Out_Immediate_Data),
        .Out_Rd(Out_Rd), .Out_RegWrite(Out_RegWrite), .Out_MemtoReg(Out_MemtoReg),
        .Out_PC(Out_PC), .Out_halt(Out_halt), .stall(stall), .misalign(misalign),
        .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Load result from plain shift/mask arithmetic; signed values via subtraction.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> (8 * off)) & 32'hff;
            if (!uns && v >= 32'h80) v = v - 32'h100;
        end else if (sz == 2'd1) begin
            v = (w >> (off[1] ? 16 : 0)) & 32'hffff;
            if (!uns && v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // One instruction held on the EX/MEM inputs until the model says it leaves.
    // lat: cycle index at which mem_ack is driven (-1 = never); rst_at: cycle with rst=1.
    task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic halt, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata,
                          input int lat, input int rst_at);
        logic [4:0]  rdn = 5'($urandom);
        logic        rw  = 1'($urandom);
        logic [1:0]  m2r = 2'($urandom);
        logic [31:0] pc  = $urandom;
        logic [1:0]  off = addr[1:0];
        logic        memop = (rd | wr) & ~halt;
        logic        algn;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        algn = (sz == 2'd0) || (sz == 2'd1 && !off[0]) || (sz[1] && off == 2'd0);
        ebe  = !wr ? 4'hf : (sz == 2'd0) ? 4'(32'd1 << off) :
               (sz == 2'd1) ? (off[1] ? 4'hc : 4'h3) : 4'hf;
        ewd  = (sz == 2'd0) ? {24'h0, sdata[7:0]} * 32'h01010101 :
               (sz == 2'd1) ? {16'h0, sdata[15:0]} * 32'h00010001 : sdata;
        for (int c = 0; c <= T + 1; c++) begin
            logic done, e_req, e_stall, e_mis, e_err, bub, cpl;
            @(posedge clk);
            #1;
            rst = (c == rst_at);
            In_Address = addr; In_Store_Data = sdata; In_MemRead = rd; In_MemWrite = wr;
            In_MemSize = sz; In_MemUnsigned = uns; In_halt = halt; In_Rd = rdn;
            In_RegWrite = rw; In_MemtoReg = m2r; In_PC = pc;
            mem_ack   = (c == lat);
            mem_rdata = (c == lat) ? rdata : $urandom;
            @(negedge clk);
            {e_req, e_stall, e_mis, e_err, bub, cpl} = '0;
            done = 1'b1;
            if (c == rst_at) bub = 1'b1;
            else if (!memop) bub = 1'b0;
            else if (!algn) {e_mis, bub} = 2'b11;
            else if (c == lat) {e_req, cpl} = 2'b11;
            else if (c == T) {e_err, bub} = 2'b11;
            else begin
                {e_req, e_stall, bub} = 3'b111;
                done = 1'b0;
            end
            chk("mem_req", 32'(mem_req), 32'(e_req));
            chk("stall", 32'(stall), 32'(e_stall));
            chk("misalign", 32'(misalign), 32'(e_mis));
            chk("bus_err", 32'(bus_err), 32'(e_err));
            chk("Out_RegWrite", 32'(Out_RegWrite), 32'(rw & ~bub));
            chk("Out_Rd", 32'(Out_Rd), bub ? 32'd0 : 32'(rdn));
            chk("Out_halt", 32'(Out_halt), 32'(halt & ~bub));
            chk("Out_RAM_Data", Out_RAM_Data,
                (cpl && rd && !wr) ? ref_load(rdata, off, sz, uns) : 32'd0);
            chk("Out_Immediate_Data", Out_Immediate_Data, addr);
            chk("Out_PC", Out_PC, pc);
            chk("Out_MemtoReg", 32'(Out_MemtoReg), 32'(m2r));
            if (e_req) begin
                chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
                chk("mem_we", 32'(mem_we), 32'(wr));
                chk("mem_be", 32'(mem_be), 32'(ebe));
                if (wr) chk("mem_wdata", mem_wdata, ewd);
            end
            if (done) break;
        end
    endtask

    initial begin
        rst = 1'b1;
        {In_Address, In_Store_Data, In_PC, mem_rdata} = '0;
        {In_MemRead, In_MemWrite, In_MemUnsigned, In_RegWrite, In_halt, mem_ack} = '0;
        {In_MemSize, In_MemtoReg, In_Rd} = '0;
        repeat (2) @(posedge clk);
        // Reset holds everything quiet even with a pending load and an ack.
        run_op(1, 0, 2'd2, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
        // Zero-latency word load.
        run_op(1, 0, 2'd2, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, -1);
        // Signed, then unsigned, byte load from the top lane.
        run_op(1, 0, 2'd0, 0, 0, 32'h103, 32'h0, 32'h80112233, 0, -1);
        run_op(1, 0, 2'd0, 1, 0, 32'h103, 32'h0, 32'h80112233, 0, -1);
        // Upper-half store acked after three stall cycles.
        run_op(0, 1, 2'd1, 0, 0, 32'h202, 32'h0000ABCD, 32'h0, 3, -1);
        // Misaligned word load.
        run_op(1, 0, 2'd2, 0, 0, 32'h101, 32'h0, 32'h12345678, 0, -1);
        // No ack at all: timeout.
        run_op(1, 0, 2'd2, 0, 0, 32'h300, 32'h0, 32'h0, -1, -1);
        // Reset in the second WAIT cycle, then a late ack that must be ignored.
        run_op(0, 1, 2'd2, 0, 0, 32'h400, 32'h11223344, 32'h0, -1, 2);
        run_op(0, 0, 2'd2, 0, 0, 32'h404, 32'h0, 32'h0, 0, -1);
        // Full timeout again proves the counter restarted.
        run_op(1, 0, 2'd2, 0, 0, 32'h408, 32'h0, 32'h0, -1, -1);
        // Halt overrides a load; size 11 acts as word; read+write acts as write.
        run_op(1, 0, 2'd2, 0, 1, 32'h500, 32'h0, 32'hCAFEF00D, 0, -1);
        run_op(0, 1, 2'd3, 0, 0, 32'h504, 32'hA5A5_5A5A, 32'h0, 1, -1);
        run_op(1, 1, 2'd0, 0, 0, 32'h509, 32'h0000_00C3, 32'hFFFF_FFFF, 0, -1);
        // Ack on the last cycle before timeout still completes.
        run_op(1, 0, 2'd1, 0, 0, 32'h60E, 32'h0, 32'h8001_7FFF, T, -1);
        for (int i = 0; i < 80; i++) begin
            int lat;
            lat = int'($urandom_range(0, 5));
            if (lat == 5) lat = -1;
            run_op(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                   ($urandom_range(0, 9) == 0), $urandom, $urandom, $urandom, lat, -1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
